// File: rtl/read_control_pkg.sv
// read_control_pkg: shared types and default sizing for the event-buffer readout block.
// Revision 1.0
`default_nettype none
package read_control_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int EVT_LEN_DEF = 16;
  localparam int NSLOT_DEF   = 64;
  localparam int FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SUBMIT = 2'd1,
    ST_READ   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/read_control_out_fifo.sv
// rc_out_fifo: 4-deep output FIFO with flush; simultaneous push/pop honoured when full.
// Revision 1.0
`default_nettype none
module rc_out_fifo
  import read_control_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [2:0]       count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push, w_pop;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign w_pop  = pop_i && (count_q != '0);
  assign w_push = push_i && ((count_q != FULL_CNT) || w_pop);

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + 1'b1;
      if (w_pop)  rptr_d = rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = 3'(count_q);

endmodule
`default_nettype wire

// File: rtl/read_control.sv
// read_control: reads one queued event from the slot buffer and streams it out with credit-based flow control.
// Revision 1.0
`default_nettype none
module read_control
  import read_control_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int EVT_LEN = EVT_LEN_DEF,
  parameter  int NSLOT   = NSLOT_DEF,
  localparam int SLOT_W  = $clog2(NSLOT),
  localparam int IDX_W   = $clog2(EVT_LEN),
  localparam int ADDR_W  = SLOT_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live_rising,
  input  logic              r_request,
  output logic              r_submit,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic [SLOT_W-1:0] rd_slot
);

  localparam logic [3:0]       OUTST_MAX = 4'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(EVT_LEN - 1);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        vld_q, vld_d;
  logic [1:0]        lst_q, lst_d;
  logic [1:0]        drop_q, drop_d;

  logic [2:0]        w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W:0]   w_head;
  logic              w_pop, w_push, w_credit;
  logic [3:0]        w_outst;

  assign w_pop    = tx_valid && tx_ready;
  assign w_push   = vld_q[1] && (drop_q == 2'd0);
  assign w_outst  = {1'b0, w_fifo_count} + {3'b000, vld_q[0]} + {3'b000, vld_q[1]} - {3'b000, w_pop};
  assign w_credit = (w_outst < OUTST_MAX);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    r_submit  = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      ST_IDLE:   if (r_request) state_d = ST_SUBMIT;
      ST_SUBMIT: begin
        r_submit = 1'b1;
        idx_d    = '0;
        state_d  = ST_READ;
      end
      ST_READ: begin
        if (w_credit) begin
          mem_rd_en = 1'b1;
          idx_d     = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && tx_last) begin
          state_d = ST_IDLE;
          slot_d  = slot_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (live_rising) begin
      state_d   = ST_IDLE;
      slot_d    = '0;
      idx_d     = '0;
      r_submit  = 1'b0;
      mem_rd_en = 1'b0;
    end
  end

  // Reads still one stage from returning at abort are counted off as they land.
  always_comb begin
    vld_d  = {vld_q[0], mem_rd_en};
    lst_d  = {lst_q[0], mem_rd_en && (idx_q == IDX_LAST)};
    drop_d = drop_q;
    if (live_rising)                       drop_d = {1'b0, vld_q[0]};
    else if (vld_q[1] && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      drop_q  <= drop_d;
    end
  end

  rc_out_fifo #(
    .WIDTH(DATA_W + 1)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (live_rising),
    .push_i     (w_push),
    .push_data_i({lst_q[1], mem_rd_data}),
    .pop_i      (w_pop),
    .head_o     (w_head),
    .empty_o    (w_fifo_empty),
    .count_o    (w_fifo_count)
  );

  assign tx_valid    = !w_fifo_empty;
  assign tx_data     = tx_valid ? w_head[DATA_W-1:0] : '0;
  assign tx_last     = tx_valid && w_head[DATA_W];
  assign mem_rd_addr = {slot_q, idx_q};
  assign busy        = (state_q != ST_IDLE);
  assign rd_slot     = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_read_control.sv
// tb_read_control: directed bench with an event-level reference model and per-cycle output comparison.
// Revision 1.0
`default_nettype none
module tb_read_control;

  localparam int DATA_W  = 32;
  localparam int EVT_LEN = 16;
  localparam int NSLOT   = 64;
  localparam int ADDR_W  = 10;
  localparam int SLOT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              live_rising = 1'b0;
  logic              r_request = 1'b0;
  logic              tx_ready = 1'b1;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              r_submit, mem_rd_en, tx_valid, tx_last, busy;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] tx_data;
  logic [SLOT_W-1:0] rd_slot;

  read_control #(.DATA_W(DATA_W), .EVT_LEN(EVT_LEN), .NSLOT(NSLOT)) dut (
    .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .r_request(r_request),
    .r_submit(r_submit), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .rd_slot(rd_slot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Buffer contents: address plus an abort epoch so stale returns are recognisable.
  function automatic logic [31:0] mem_word(input int ep, input int addr);
    return {8'(ep), 14'h0, 10'(addr)};
  endfunction

  typedef struct packed { logic [31:0] d; logic l; } word_t;
  word_t exp_q[$];
  int cyc = 0, m_slot = 0, m_idx = 0, epoch = 0, outst = 0;
  bit m_reading = 0;
  int last_sub = -100, n_sub = 0, n_acc = 0;
  int ev_first_en = -1, ev_first_val = -1, ev_last_acc = -1, ev_first_addr = -1;
  bit h1_v = 0, h2_v = 0;
  int h1_a = 0, h2_a = 0, h1_e = 0, h2_e = 0;
  bit prev_stall = 0, prev_live = 0;
  logic [31:0] prev_d = '0;
  logic prev_l = 1'b0;

  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_slot = 0; m_idx = 0; m_reading = 0; outst = 0;
      last_sub = -100; prev_stall = 0; prev_live = 0;
    end else begin
      check("rd_slot", 64'(rd_slot), 64'(m_slot));
      if (r_submit) begin
        check("submit_spacing_ok", 64'((cyc - last_sub) >= EVT_LEN + 3), 64'd1);
        last_sub = cyc; n_sub++; m_reading = 1; m_idx = 0;
        ev_first_en = -1; ev_first_val = -1; ev_last_acc = -1;
        for (int i = 0; i < EVT_LEN; i++)
          exp_q.push_back('{d: mem_word(epoch, m_slot * EVT_LEN + i), l: (i == EVT_LEN - 1)});
      end
      if (mem_rd_en) begin
        check("rd_in_window", 64'(m_reading), 64'd1);
        check("rd_addr", 64'(mem_rd_addr), 64'(m_slot * EVT_LEN + m_idx));
        if (m_idx == 0) begin ev_first_en = cyc; ev_first_addr = int'(mem_rd_addr); end
        m_idx++;
        if (m_idx == EVT_LEN) m_reading = 0;
        outst++;
      end
      if (prev_stall && !prev_live)
        check("tx_hold", 64'({tx_valid, tx_last, tx_data}), 64'({1'b1, prev_l, prev_d}));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_spurious", 64'(tx_valid), 64'd0);
        else begin
          w = exp_q.pop_front();
          check("tx_data", 64'(tx_data), 64'(w.d));
          check("tx_last", 64'(tx_last), 64'(w.l));
          if (ev_first_val < 0) ev_first_val = cyc;
          ev_last_acc = cyc;
          n_acc++;
          if (w.l) m_slot = (m_slot + 1) % NSLOT;
        end
        outst--;
      end
      check("outstanding_le4", 64'(outst <= 4), 64'd1);
      if (live_rising) begin
        exp_q.delete();
        m_slot = 0; m_idx = 0; m_reading = 0; outst = 0; last_sub = -100; epoch++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data; prev_l = tx_last; prev_live = live_rising;
    end
    mem_rd_data = h2_v ? mem_word(h2_e, h2_a) : 32'hDEADBEEF;
    h2_v = h1_v; h2_a = h1_a; h2_e = h1_e;
    h1_v = mem_rd_en; h1_a = int'(mem_rd_addr); h1_e = epoch;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin tick(); i++; end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic pulse_request();
    r_request = 1'b1;
    tick();
    r_request = 1'b0;
  endtask

  task automatic wait_reads(input int n, input int budget);
    int ne = 0, g = 0;
    while (ne < n && g < budget) begin
      if (mem_rd_en) ne++;
      if (ne < n) tick();
      g++;
    end
    check("reads_seen", 64'(ne), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset: r_request already high must be ignored until release.
    r_request = 1'b1;
    tx_ready  = 1'b1;
    repeat (3) tick();
    check("rst_r_submit", 64'(r_submit), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_last", 64'(tx_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);

    // Single event straight out of reset.
    n_sub = 0; n_acc = 0;
    rst_n = 1'b1;
    tick();
    check("submit_first_edge", 64'(r_submit), 64'd1);
    r_request = 1'b0;
    wait_idle("t1_idle", 100);
    check("t1_submits", 64'(n_sub), 64'd1);
    check("t1_words", 64'(n_acc), 64'd16);
    check("t1_first_addr", 64'(ev_first_addr), 64'd0);
    check("t1_rd_slot", 64'(rd_slot), 64'd1);
    check("t1_first_valid_lat", 64'(ev_first_val - ev_first_en), 64'd3);
    check("t1_consecutive", 64'(ev_last_acc - ev_first_val), 64'd15);

    // Random backpressure.
    n_sub = 0; n_acc = 0;
    pulse_request();
    begin
      int i = 0;
      while (busy && i < 400) begin
        tx_ready = 1'($urandom_range(0, 1));
        tick();
        i++;
      end
    end
    tx_ready = 1'b1;
    check("t2_idle", 64'(busy), 64'd0);
    check("t2_words", 64'(n_acc), 64'd16);
    check("t2_first_addr", 64'(ev_first_addr), 64'd16);
    check("t2_rd_slot", 64'(rd_slot), 64'd2);

    // Abort two cycles after the 5th read with reads in flight.
    pulse_request();
    wait_reads(5, 50);
    tick();
    tick();
    live_rising = 1'b1;
    tick();
    live_rising = 1'b0;
    check("t4_busy_after_abort", 64'(busy), 64'd0);
    check("t4_tx_valid_after_abort", 64'(tx_valid), 64'd0);
    check("t4_rd_slot_after_abort", 64'(rd_slot), 64'd0);
    repeat (4) tick();
    check("t4_no_stale", 64'(tx_valid), 64'd0);
    n_acc = 0;
    pulse_request();
    wait_idle("t4_new_idle", 100);
    check("t4_new_first_addr", 64'(ev_first_addr), 64'd0);
    check("t4_new_words", 64'(n_acc), 64'd16);
    check("t4_new_rd_slot", 64'(rd_slot), 64'd1);

    // Back-to-back events starting from slot 0.
    live_rising = 1'b1;
    tick();
    live_rising = 1'b0;
    n_sub = 0; n_acc = 0;
    r_request = 1'b1;
    begin
      int g = 0;
      while (n_sub < 3 && g < 200) begin tick(); g++; end
    end
    r_request = 1'b0;
    wait_idle("t3_idle", 100);
    check("t3_submits", 64'(n_sub), 64'd3);
    check("t3_words", 64'(n_acc), 64'd48);
    check("t3_last_first_addr", 64'(ev_first_addr), 64'd32);
    check("t3_rd_slot", 64'(rd_slot), 64'd3);

    // Run up to slot 63 and wrap.
    r_request = 1'b1;
    begin
      int g = 0;
      while (n_sub < 64 && g < 3000) begin tick(); g++; end
    end
    r_request = 1'b0;
    wait_idle("t5_idle", 100);
    check("t5_submits", 64'(n_sub), 64'd64);
    check("t5_words", 64'(n_acc), 64'd1024);
    check("t5_first_addr", 64'(ev_first_addr), 64'd1008);
    check("t5_rd_slot_wrap", 64'(rd_slot), 64'd0);

    // Asynchronous reset in the middle of READ.
    pulse_request();
    wait_reads(3, 50);
    check("t6_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_r_submit", 64'(r_submit), 64'd0);
    check("t6_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("t6_tx_valid", 64'(tx_valid), 64'd0);
    check("t6_tx_last", 64'(tx_last), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("t6_tx_data", 64'(tx_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_idle_after", 64'(busy), 64'd0);
    check("t6_rd_slot_after", 64'(rd_slot), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
